// File: rtl/pcie_datalink_pkg.sv
// pcie_datalink_pkg: shared grant/state types, timer defaults and the egress arbitration rule
package pcie_datalink_pkg;

    localparam int FC_TIMEOUT_DEF   = 1024;
    localparam int ACK_TIMEOUT_DEF  = 256;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {NONE = 2'd0, ACK = 2'd1, FC = 2'd2, TLP = 2'd3} dl_grant_e;

    typedef enum logic [1:0] {IDLE = 2'd0, G_ACK = 2'd1, G_FC = 2'd2, G_TLP = 2'd3} dl_sched_state_e;

    // ACK > FC > TLP, except a starved TLP jumps the queue
    function automatic dl_grant_e dl_arbitrate(logic ack, logic fc, logic tlp, logic starved);
        return (starved && tlp) ? TLP : ack ? ACK : fc ? FC : tlp ? TLP : NONE;
    endfunction

endpackage

// File: rtl/pcie_dl_sat_timer.sv
// pcie_dl_sat_timer: saturating up-counter; clear beats enable, expired while parked at LIMIT-1
module pcie_dl_sat_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = LIMIT > 1 ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] MAX = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt <= '0;
        else cnt <= clr ? '0 : (en && cnt != MAX) ? cnt + 1'b1 : cnt;
    end

    assign expired = cnt == MAX;

endmodule

// File: rtl/pcie_dl_tx_scheduler.sv
// pcie_dl_tx_scheduler: packet-granular merge of ACK/NAK, FC and TLP streams onto the PHY stream,
// with a TLP starvation guard and the FC-update / ACK-latency timers
module pcie_dl_tx_scheduler
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH   = 3,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int FC_TIMEOUT   = FC_TIMEOUT_DEF,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] s_ack_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_ack_axis_tkeep,
    input  logic                  s_ack_axis_tvalid,
    input  logic                  s_ack_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_ack_axis_tuser,
    output logic                  s_ack_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_fc_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_fc_axis_tkeep,
    input  logic                  s_fc_axis_tvalid,
    input  logic                  s_fc_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_fc_axis_tuser,
    output logic                  s_fc_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,
    output logic [DATA_WIDTH-1:0] m_phy_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_phy_axis_tkeep,
    output logic                  m_phy_axis_tvalid,
    output logic                  m_phy_axis_tlast,
    output logic [USER_WIDTH-1:0] m_phy_axis_tuser,
    input  logic                  m_phy_axis_tready,
    input  logic                  dl_active_i,
    input  logic                  ack_pending_i,
    output logic                  fc_update_req_o,
    output logic                  ack_overdue_o,
    output logic [1:0]            grant_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    dl_sched_state_e state, state_nxt;
    logic [SW-1:0]   starve_cnt, starve_nxt;
    logic            mid_pkt;
    logic            tlp_el, ack_req, fc_req, tlp_req, hs, last_hs, first_hs;

    assign tlp_el   = s_tlp_axis_tvalid && dl_active_i;
    // The source finishing a packet is masked: its tvalid still belongs to the beat just taken
    assign ack_req  = s_ack_axis_tvalid && state != G_ACK;
    assign fc_req   = s_fc_axis_tvalid && state != G_FC;
    assign tlp_req  = tlp_el && state != G_TLP;
    assign hs       = m_phy_axis_tvalid && m_phy_axis_tready;
    assign last_hs  = hs && m_phy_axis_tlast;
    assign first_hs = hs && !mid_pkt;
    assign grant_o  = state;

    always_comb begin
        starve_nxt = starve_cnt;
        state_nxt  = state;
        if (last_hs)
            starve_nxt = (state == G_TLP || !tlp_el) ? '0 :
                         (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
        if (state == IDLE || last_hs)
            state_nxt = dl_sched_state_e'(dl_arbitrate(ack_req, fc_req, tlp_req,
                                                       starve_nxt >= SW'(STARVE_LIMIT)));
    end

    always_comb begin
        m_phy_axis_tdata  = '0;
        m_phy_axis_tkeep  = '0;
        m_phy_axis_tvalid = 1'b0;
        m_phy_axis_tlast  = 1'b0;
        m_phy_axis_tuser  = '0;
        s_ack_axis_tready = 1'b0;
        s_fc_axis_tready  = 1'b0;
        s_tlp_axis_tready = 1'b0;
        case (state)
            G_ACK: begin
                m_phy_axis_tdata  = s_ack_axis_tdata;
                m_phy_axis_tkeep  = s_ack_axis_tkeep;
                m_phy_axis_tvalid = s_ack_axis_tvalid;
                m_phy_axis_tlast  = s_ack_axis_tlast;
                m_phy_axis_tuser  = s_ack_axis_tuser;
                s_ack_axis_tready = m_phy_axis_tready;
            end
            G_FC: begin
                m_phy_axis_tdata  = s_fc_axis_tdata;
                m_phy_axis_tkeep  = s_fc_axis_tkeep;
                m_phy_axis_tvalid = s_fc_axis_tvalid;
                m_phy_axis_tlast  = s_fc_axis_tlast;
                m_phy_axis_tuser  = s_fc_axis_tuser;
                s_fc_axis_tready  = m_phy_axis_tready;
            end
            G_TLP: begin
                m_phy_axis_tdata  = s_tlp_axis_tdata;
                m_phy_axis_tkeep  = s_tlp_axis_tkeep;
                m_phy_axis_tvalid = s_tlp_axis_tvalid;
                m_phy_axis_tlast  = s_tlp_axis_tlast;
                m_phy_axis_tuser  = s_tlp_axis_tuser;
                s_tlp_axis_tready = m_phy_axis_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mid_pkt    <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            mid_pkt    <= hs ? !m_phy_axis_tlast : mid_pkt;
        end
    end

    pcie_dl_sat_timer #(.LIMIT(FC_TIMEOUT)) u_fc_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     (first_hs && state == G_FC),
        .en      (1'b1),
        .expired (fc_update_req_o)
    );

    pcie_dl_sat_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr     ((first_hs && state == G_ACK) || !ack_pending_i),
        .en      (ack_pending_i),
        .expired (ack_overdue_o)
    );

endmodule

// File: tb/tb_pcie_dl_tx_scheduler.sv
// tb_pcie_dl_tx_scheduler: directed checks of arbitration order, starvation, link-down masking,
// backpressure, DLLP timers and async reset
module tb_pcie_dl_tx_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] s_ack_axis_tdata, s_fc_axis_tdata, s_tlp_axis_tdata, m_phy_axis_tdata;
    logic [3:0]  s_ack_axis_tkeep, s_fc_axis_tkeep, s_tlp_axis_tkeep, m_phy_axis_tkeep;
    logic [2:0]  s_ack_axis_tuser, s_fc_axis_tuser, s_tlp_axis_tuser, m_phy_axis_tuser;
    logic        s_ack_axis_tvalid, s_fc_axis_tvalid, s_tlp_axis_tvalid, m_phy_axis_tvalid;
    logic        s_ack_axis_tlast, s_fc_axis_tlast, s_tlp_axis_tlast, m_phy_axis_tlast;
    logic        s_ack_axis_tready, s_fc_axis_tready, s_tlp_axis_tready, m_phy_axis_tready;
    logic        dl_active_i, ack_pending_i, fc_update_req_o, ack_overdue_o;
    logic [1:0]  grant_o;

    int errors = 0;
    int checks = 0;
    int b;
    logic [1:0] exp_g [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3};

    always #5 clk_i = ~clk_i;

    pcie_dl_tx_scheduler #(
        .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3),
        .STARVE_LIMIT(4), .FC_TIMEOUT(16), .ACK_TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_ack_axis_tdata(s_ack_axis_tdata), .s_ack_axis_tkeep(s_ack_axis_tkeep),
        .s_ack_axis_tvalid(s_ack_axis_tvalid), .s_ack_axis_tlast(s_ack_axis_tlast),
        .s_ack_axis_tuser(s_ack_axis_tuser), .s_ack_axis_tready(s_ack_axis_tready),
        .s_fc_axis_tdata(s_fc_axis_tdata), .s_fc_axis_tkeep(s_fc_axis_tkeep),
        .s_fc_axis_tvalid(s_fc_axis_tvalid), .s_fc_axis_tlast(s_fc_axis_tlast),
        .s_fc_axis_tuser(s_fc_axis_tuser), .s_fc_axis_tready(s_fc_axis_tready),
        .s_tlp_axis_tdata(s_tlp_axis_tdata), .s_tlp_axis_tkeep(s_tlp_axis_tkeep),
        .s_tlp_axis_tvalid(s_tlp_axis_tvalid), .s_tlp_axis_tlast(s_tlp_axis_tlast),
        .s_tlp_axis_tuser(s_tlp_axis_tuser), .s_tlp_axis_tready(s_tlp_axis_tready),
        .m_phy_axis_tdata(m_phy_axis_tdata), .m_phy_axis_tkeep(m_phy_axis_tkeep),
        .m_phy_axis_tvalid(m_phy_axis_tvalid), .m_phy_axis_tlast(m_phy_axis_tlast),
        .m_phy_axis_tuser(m_phy_axis_tuser), .m_phy_axis_tready(m_phy_axis_tready),
        .dl_active_i(dl_active_i), .ack_pending_i(ack_pending_i),
        .fc_update_req_o(fc_update_req_o), .ack_overdue_o(ack_overdue_o), .grant_o(grant_o)
    );

    task automatic cyc;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        s_ack_axis_tdata = 32'hA0; s_ack_axis_tkeep = 4'h1; s_ack_axis_tuser = 3'd1;
        s_fc_axis_tdata  = 32'hF0; s_fc_axis_tkeep  = 4'h3; s_fc_axis_tuser  = 3'd2;
        s_tlp_axis_tdata = 32'h10; s_tlp_axis_tkeep = 4'hF; s_tlp_axis_tuser = 3'd3;
        s_ack_axis_tvalid = 0; s_fc_axis_tvalid = 0; s_tlp_axis_tvalid = 0;
        s_ack_axis_tlast = 1; s_fc_axis_tlast = 1; s_tlp_axis_tlast = 0;
        m_phy_axis_tready = 1; dl_active_i = 1; ack_pending_i = 0;
        #1 rst_ni = 0;
        #1;
        chk("rst_tvalid", m_phy_axis_tvalid, 0);
        chk("rst_tlast", m_phy_axis_tlast, 0);
        chk("rst_data", {m_phy_axis_tdata[27:0], m_phy_axis_tkeep}, 0);
        chk("rst_user", m_phy_axis_tuser, 0);
        chk("rst_readies", {s_ack_axis_tready, s_fc_axis_tready, s_tlp_axis_tready}, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_timers", {fc_update_req_o, ack_overdue_o}, 0);

        // Timers from reset release, no traffic
        repeat (2) cyc;
        ack_pending_i = 1; rst_ni = 1;
        repeat (6) cyc; settle; chk("ack_t6", ack_overdue_o, 0);
        cyc; settle; chk("ack_t7", ack_overdue_o, 1);
        repeat (7) cyc; settle; chk("fc_t14", fc_update_req_o, 0);
        cyc; settle; chk("fc_t15", fc_update_req_o, 1);
        cyc; ack_pending_i = 0; s_fc_axis_tvalid = 1; s_fc_axis_tdata = 32'hF1;
        settle;
        chk("fc_hold", fc_update_req_o, 1);
        chk("idle_grant", grant_o, 0);
        chk("idle_tvalid", m_phy_axis_tvalid, 0);
        cyc; settle;
        chk("fc_grant", grant_o, 2);
        chk("fc_data", m_phy_axis_tdata, 32'hF1);
        chk("fc_req_before_accept", fc_update_req_o, 1);
        chk("ack_cleared", ack_overdue_o, 0);
        cyc; s_fc_axis_tvalid = 0; settle;
        chk("fc_req_cleared", fc_update_req_o, 0);
        chk("fc_done_grant", grant_o, 0);

        // Simultaneous arrivals: ACK, FC, 4-beat TLP
        cyc;
        s_ack_axis_tvalid = 1; s_ack_axis_tdata = 32'hA0;
        s_fc_axis_tvalid = 1; s_fc_axis_tdata = 32'hF0;
        s_tlp_axis_tvalid = 1; s_tlp_axis_tdata = 32'h10; s_tlp_axis_tlast = 0;
        settle; chk("sim_c0_tvalid", m_phy_axis_tvalid, 0);
        cyc; settle;
        chk("sim_c1_grant", grant_o, 1);
        chk("sim_c1_data", m_phy_axis_tdata, 32'hA0);
        chk("sim_c1_keep_user", {m_phy_axis_tkeep, m_phy_axis_tuser}, {4'h1, 3'd1});
        chk("sim_c1_readies", {s_ack_axis_tready, s_fc_axis_tready, s_tlp_axis_tready}, 3'b100);
        cyc; s_ack_axis_tvalid = 0; settle;
        chk("sim_c2_grant", grant_o, 2);
        chk("sim_c2_data", m_phy_axis_tdata, 32'hF0);
        chk("sim_c2_keep_user", {m_phy_axis_tkeep, m_phy_axis_tuser}, {4'h3, 3'd2});
        cyc; s_fc_axis_tvalid = 0;
        for (int i = 0; i < 4; i++) begin
            settle;
            chk($sformatf("sim_tlp%0d_grant", i), grant_o, 3);
            chk($sformatf("sim_tlp%0d_tvalid", i), m_phy_axis_tvalid, 1);
            chk($sformatf("sim_tlp%0d_data", i), m_phy_axis_tdata, 32'h10 + i);
            chk($sformatf("sim_tlp%0d_tlast", i), m_phy_axis_tlast, i == 3);
            cyc;
            s_tlp_axis_tdata = 32'h10 + i + 1;
            s_tlp_axis_tlast = (i + 1 == 3);
        end
        s_tlp_axis_tvalid = 0; s_tlp_axis_tlast = 0; settle;
        chk("sim_end_grant", grant_o, 0);

        // Starvation: ACK and FC stream continuously with a 1-beat TLP waiting
        cyc;
        s_ack_axis_tvalid = 1; s_ack_axis_tdata = 32'hA1;
        s_fc_axis_tvalid = 1; s_fc_axis_tdata = 32'hF2;
        s_tlp_axis_tvalid = 1; s_tlp_axis_tdata = 32'h20; s_tlp_axis_tlast = 1;
        settle; chk("stv_idle", grant_o, 0);
        for (int i = 0; i < 5; i++) begin
            cyc; settle;
            chk($sformatf("stv_grant%0d", i), grant_o, exp_g[i]);
        end
        chk("stv_tlp_data", m_phy_axis_tdata, 32'h20);
        s_ack_axis_tvalid = 0; s_fc_axis_tvalid = 0;
        cyc; s_tlp_axis_tvalid = 0; s_tlp_axis_tlast = 0; settle;
        chk("stv_end_grant", grant_o, 0);
        chk("stv_cnt_cleared", dut.starve_cnt, 0);

        // Link down masks TLP; dropping it mid-packet does not abort
        cyc; dl_active_i = 0; s_tlp_axis_tvalid = 1; s_tlp_axis_tdata = 32'h30;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk($sformatf("ld%0d_grant", i), grant_o, 0);
            chk($sformatf("ld%0d_tready", i), s_tlp_axis_tready, 0);
            cyc;
        end
        dl_active_i = 1; settle; chk("ld_up_idle", grant_o, 0);
        cyc; dl_active_i = 0; settle;
        chk("ld_tlp_grant", grant_o, 3);
        chk("ld_tlp_data0", m_phy_axis_tdata, 32'h30);
        chk("ld_tlp_tready", s_tlp_axis_tready, 1);
        cyc; s_tlp_axis_tvalid = 0; settle;
        chk("ld_stall_tvalid", m_phy_axis_tvalid, 0);
        chk("ld_stall_grant", grant_o, 3);
        cyc; s_tlp_axis_tvalid = 1; s_tlp_axis_tdata = 32'h31; s_tlp_axis_tlast = 1; settle;
        chk("ld_tlp_data1", {m_phy_axis_tvalid, m_phy_axis_tlast, m_phy_axis_tdata[29:0]}, {2'b11, 30'h31});
        cyc; s_tlp_axis_tvalid = 0; s_tlp_axis_tlast = 0; dl_active_i = 1; settle;
        chk("ld_end_grant", grant_o, 0);

        // Backpressure 1,0,1,0 during a 4-beat TLP with an ACK waiting
        cyc; s_tlp_axis_tvalid = 1; s_tlp_axis_tdata = 32'h40; settle;
        chk("bp_idle", grant_o, 0);
        cyc; s_ack_axis_tvalid = 1; s_ack_axis_tdata = 32'hA5;
        b = 0;
        for (int c = 1; c <= 7; c++) begin
            m_phy_axis_tready = c[0];
            settle;
            chk($sformatf("bp%0d_grant", c), grant_o, 3);
            chk($sformatf("bp%0d_data", c), m_phy_axis_tdata, 32'h40 + b);
            chk($sformatf("bp%0d_tlast", c), m_phy_axis_tlast, b == 3);
            chk($sformatf("bp%0d_readies", c), {s_ack_axis_tready, s_tlp_axis_tready}, {1'b0, c[0]});
            cyc;
            if (m_phy_axis_tready) begin
                b++;
                s_tlp_axis_tdata = 32'h40 + b;
                s_tlp_axis_tlast = (b == 3);
            end
        end
        s_tlp_axis_tvalid = 0; s_tlp_axis_tlast = 0; m_phy_axis_tready = 1; settle;
        chk("bp_ack_grant", grant_o, 1);
        chk("bp_ack_data", m_phy_axis_tdata, 32'hA5);
        cyc; s_ack_axis_tvalid = 0; settle;
        chk("bp_end_grant", grant_o, 0);

        // Async reset during beat 2 of a TLP
        cyc; s_tlp_axis_tvalid = 1; s_tlp_axis_tdata = 32'h50; settle;
        cyc; settle; chk("rr_beat0", m_phy_axis_tdata, 32'h50);
        cyc; s_tlp_axis_tdata = 32'h51;
        cyc; s_tlp_axis_tdata = 32'h52;
        #1 chk("rr_beat2", {grant_o, m_phy_axis_tdata[29:0]}, {2'd3, 30'h52});
        rst_ni = 0;
        #1;
        chk("rr_tvalid", m_phy_axis_tvalid, 0);
        chk("rr_grant", grant_o, 0);
        chk("rr_tready", s_tlp_axis_tready, 0);
        chk("rr_data", {m_phy_axis_tdata[27:0], m_phy_axis_tkeep}, 0);
        chk("rr_tlast_timers", {m_phy_axis_tlast, fc_update_req_o, ack_overdue_o}, 0);
        s_tlp_axis_tvalid = 0;
        settle; rst_ni = 1;
        cyc; s_ack_axis_tvalid = 1; s_ack_axis_tdata = 32'hA7; settle;
        chk("rr_idle", {grant_o, m_phy_axis_tvalid}, 0);
        cyc; settle;
        chk("rr_ack_grant", grant_o, 1);
        chk("rr_ack_data", {m_phy_axis_tvalid, m_phy_axis_tdata[30:0]}, {1'b1, 31'hA7});
        cyc; s_ack_axis_tvalid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
